// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the EX stage and the multiply/divide unit.
// The master drives the operation request and the slave returns busy and the HI/LO registers.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, input busy, hi, lo);
  modport slave  (input start, op, a, b, hi_we, lo_we, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu unit with HI/LO registers and mthi/mtlo writes.
// Defining MD_MADD_EN enables madd/maddu/msub/msubu (ops 4-7) accumulating into {HI,LO}.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  md
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;
`endif

  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]             state_r;
  logic [2:0]             op_r;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [WIDTH-1:0]       hi_r;
  logic [WIDTH-1:0]       lo_r;
  logic [CNT_W-1:0]       cnt_r;

  logic                   op_valid_s;
  logic                   launch_s;
  logic [CNT_W-1:0]       load_cnt_s;
  logic signed [2*WIDTH-1:0] sa_ext_s;
  logic signed [2*WIDTH-1:0] sb_ext_s;
  logic [2*WIDTH-1:0]     sprod_s;
  logic [2*WIDTH-1:0]     uprod_s;
  logic signed [WIDTH-1:0] squot_s;
  logic signed [WIDTH-1:0] srem_s;
  logic [WIDTH-1:0]       uquot_s;
  logic [WIDTH-1:0]       urem_s;
  logic [2*WIDTH-1:0]     result_s;

  assign md.busy = (state_r == RUN);
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

  assign launch_s = (state_r == IDLE) && md.start && op_valid_s;

  // Decode the requested op: legality and busy-cycle count to load.
  always_comb begin
    op_valid_s = 1'b0;
    load_cnt_s = CNT_W'(MULT_CYCLES);
    case (md.op)
      OP_MULT, OP_MULTU: begin
        op_valid_s = 1'b1;
        load_cnt_s = CNT_W'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        op_valid_s = 1'b1;
        load_cnt_s = CNT_W'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        op_valid_s = 1'b1;
        load_cnt_s = CNT_W'(MULT_CYCLES);
      end
`endif
      default: begin
        op_valid_s = 1'b0;
        load_cnt_s = CNT_W'(MULT_CYCLES);
      end
    endcase
  end

  // Arithmetic works only on latched operands so forwarded a/b may change during RUN.
  assign sa_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
  assign sb_ext_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
  assign sprod_s  = sa_ext_s * sb_ext_s;
  assign uprod_s  = {W_ZERO, a_r} * {W_ZERO, b_r};
  assign squot_s  = $signed(a_r) / $signed(b_r);
  assign srem_s   = $signed(a_r) % $signed(b_r);
  assign uquot_s  = a_r / b_r;
  assign urem_s   = a_r % b_r;

  // Select the {HI,LO} value written on the retire edge, including divide corner cases.
  always_comb begin
    result_s = {hi_r, lo_r};
    case (op_r)
      OP_MULT:  result_s = sprod_s;
      OP_MULTU: result_s = uprod_s;
      OP_DIV: begin
        if (b_r == W_ZERO) begin
          result_s = {a_r, W_ONES};
        end else if ((a_r == W_MIN) && (b_r == W_ONES)) begin
          result_s = {W_ZERO, W_MIN};
        end else begin
          result_s = {srem_s, squot_s};
        end
      end
      OP_DIVU: begin
        if (b_r == W_ZERO) begin
          result_s = {a_r, W_ONES};
        end else begin
          result_s = {urem_s, uquot_s};
        end
      end
`ifdef MD_MADD_EN
      OP_MADD:  result_s = {hi_r, lo_r} + sprod_s;
      OP_MADDU: result_s = {hi_r, lo_r} + uprod_s;
      OP_MSUB:  result_s = {hi_r, lo_r} - sprod_s;
      OP_MSUBU: result_s = {hi_r, lo_r} - uprod_s;
`endif
      default:  result_s = {hi_r, lo_r};
    endcase
  end

  // FSM, operand latch, cycle counter and HI/LO update; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      op_r    <= 3'd0;
      a_r     <= W_ZERO;
      b_r     <= W_ZERO;
      cnt_r   <= {CNT_W{1'b0}};
      hi_r    <= W_ZERO;
      lo_r    <= W_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r <= RUN;
            op_r    <= md.op;
            a_r     <= md.a;
            b_r     <= md.b;
            cnt_r   <= load_cnt_s;
          end else begin
            if (md.hi_we) hi_r <= md.a;
            if (md.lo_we) lo_r <= md.a;
          end
        end
        RUN: begin
          if (cnt_r == CNT_W'(32'd1)) begin
            {hi_r, lo_r} <= result_s;
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r - CNT_W'(32'd1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table vectors, hand-written corner sequences and random ops vs. an arithmetic model.
// Build with MD_MADD_EN defined to also cover madd/maddu/msub/msubu.
module tb_md_unit;
  localparam int W     = 32;
  localparam int MULTN = 5;
  localparam int DIVN  = 10;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_if #(.WIDTH(W)) mif ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MULTN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit op_legal(input logic [2:0] o);
`ifdef MD_MADD_EN
    return 1'b1;
`else
    return (o < 3'd4);
`endif
  endfunction

  function automatic int op_cycles(input logic [2:0] o);
    if (!op_legal(o)) return 0;
    return (o == 3'd2 || o == 3'd3) ? DIVN : MULTN;
  endfunction

  // Reference behaviour from the arithmetic definitions, using 64-bit integer math.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [63:0] acc);
    int sx, sy;
    longint sp;
    logic [63:0] up;
    sx = x;
    sy = y;
    sp = longint'(sx) * longint'(sy);
    up = {32'd0, x} * {32'd0, y};
    if (!op_legal(o)) return acc;
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      3'd4: return acc + sp;
      3'd5: return acc + up;
      3'd6: return acc - sp;
      default: return acc - up;
    endcase
  endfunction

  // Launch one op, poke illegal mtlo/mthi/start during RUN, count busy cycles, check hold and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic hw,
                        input int exp_n, input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    bit hold_bad;
    logic [31:0] old_hi, old_lo;
    old_hi = mif.hi;
    old_lo = mif.lo;
    mif.start = 1'b1;
    mif.op    = o;
    mif.a     = x;
    mif.b     = y;
    mif.hi_we = hw;
    @(negedge clk);
    mif.start = 1'b0;
    mif.hi_we = 1'b0;
    if (exp_n > 0) begin
      mif.start = 1'b1;
      mif.op    = 3'($urandom_range(3, 0));
      mif.hi_we = 1'b1;
      mif.lo_we = 1'b1;
    end
    mif.a = $urandom;
    mif.b = $urandom;
    n = 0;
    hold_bad = 1'b0;
    while (mif.busy && n < 64) begin
      n++;
      if (mif.hi !== old_hi || mif.lo !== old_lo) hold_bad = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      mif.hi_we = 1'b0;
      mif.lo_we = 1'b0;
    end
    mif.start = 1'b0;
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    check({nm, " busy_cycles"}, 64'(n), 64'(exp_n));
    check({nm, " hold"}, {63'd0, hold_bad}, 64'd0);
    check({nm, " hi"}, {32'd0, mif.hi}, {32'd0, eh});
    check({nm, " lo"}, {32'd0, mif.lo}, {32'd0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic mt_write(input logic to_hi, input logic [31:0] v);
    mif.a     = v;
    mif.hi_we = to_hi;
    mif.lo_we = ~to_hi;
    @(negedge clk);
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    if (to_hi) begin
      m_hi = v;
      check("mthi", {32'd0, mif.hi}, {32'd0, v});
    end else begin
      m_lo = v;
      check("mtlo", {32'd0, mif.lo}, {32'd0, v});
    end
  endtask

  initial begin
    logic [63:0] exp;
    logic [2:0]  o;
    logic [31:0] x, y;

    vecs[0] = '{3'd0, 32'd7,          32'hFFFFFFFD, MULTN, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{3'd3, 32'd100,        32'd7,        DIVN,  32'd2,        32'd14};
    vecs[2] = '{3'd2, 32'hFFFFFFF9,   32'd2,        DIVN,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd2, 32'd5,          32'd0,        DIVN,  32'd5,        32'hFFFFFFFF};
    vecs[4] = '{3'd2, 32'h80000000,   32'hFFFFFFFF, DIVN,  32'd0,        32'h80000000};
    vecs[5] = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, MULTN, 32'hFFFFFFFE, 32'h00000001};
    vecs[6] = '{3'd3, 32'd5,          32'd0,        DIVN,  32'd5,        32'hFFFFFFFF};
    vecs[7] = '{3'd2, 32'd7,          32'hFFFFFFFE, DIVN,  32'd1,        32'hFFFFFFFD};

    reset     = 1'b0;
    mif.start = 1'b0;
    mif.op    = 3'd0;
    mif.a     = 32'd0;
    mif.b     = 32'd0;
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", {63'd0, mif.busy}, 64'd0);
    check("reset hi", {32'd0, mif.hi}, 64'd0);
    check("reset lo", {32'd0, mif.lo}, 64'd0);
    reset = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;

    mt_write(1'b1, 32'h1234);
    mt_write(1'b0, 32'h5678);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].n, vecs[i].eh, vecs[i].el,
             $sformatf("vec%0d", i));
    end

    // start together with mthi: the op launches and mthi is dropped
    mt_write(1'b1, 32'h55);
    run_op(3'd1, 32'd2, 32'd3, 1'b1, MULTN, 32'd0, 32'd6, "start_with_mthi");

`ifdef MD_MADD_EN
    mt_write(1'b1, 32'd0);
    mt_write(1'b0, 32'd10);
    run_op(3'd4, 32'd3, 32'd4, 1'b0, MULTN, 32'd0, 32'd22, "madd");
    run_op(3'd7, 32'd1, 32'd23, 1'b0, MULTN, 32'hFFFFFFFF, 32'hFFFFFFFF, "msubu");
`else
    run_op(3'd4, 32'd3, 32'd4, 1'b0, 0, m_hi, m_lo, "op4_noop");
`endif

    // reset in the third busy cycle of a divide
    mif.start = 1'b1;
    mif.op    = 3'd3;
    mif.a     = 32'd100;
    mif.b     = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset busy", {63'd0, mif.busy}, 64'd0);
    check("midreset hi", {32'd0, mif.hi}, 64'd0);
    check("midreset lo", {32'd0, mif.lo}, 64'd0);
    repeat (12) @(negedge clk);
    check("midreset late hi", {32'd0, mif.hi}, 64'd0);
    check("midreset late lo", {32'd0, mif.lo}, 64'd0);
    check("midreset late busy", {63'd0, mif.busy}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(7, 0));
      case ($urandom_range(7, 0))
        0: begin x = $urandom; y = 32'd0; end
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: begin x = $urandom_range(200, 0); y = $urandom_range(20, 1); end
        default: begin x = $urandom; y = $urandom; end
      endcase
      if ($urandom_range(3, 0) == 0) mt_write($urandom_range(1, 0) == 1, $urandom);
      exp = ref_md(o, x, y, {m_hi, m_lo});
      run_op(o, x, y, 1'b0, op_cycles(o), exp[63:32], exp[31:0], $sformatf("rand%0d op%0d", i, o));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
